// File: rtl/spi_v2_pkg.sv
// Shared types and constants for the spi_v2 byte-oriented SPI master.
package spi_v2_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CS_GAP_DEF = 2;
    localparam int unsigned HP_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STORE,
        HOLD,
        GAP
    } state_t;

    // sck half-period in clk cycles, indexed by freq (2**freq)
    localparam logic [3:0][HP_W-1:0] HALF_PERIOD_TBL = {4'd8, 4'd4, 4'd2, 4'd1};

    function automatic logic [HP_W-1:0] half_period(input logic [1:0] freq);
        return HALF_PERIOD_TBL[freq];
    endfunction

endpackage

// File: rtl/spi_v2_if.sv
// Bundle of SPI pins and TX/RX FIFO handshake signals for spi_v2.
interface spi_v2_if #(
    parameter int unsigned DATA_W = 8
);
    logic              cs;
    logic              sck;
    logic              miso;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic [DATA_W:0]   din;
    logic [1:0]        freq;
    logic              tx_fifo_empty;
    logic              rx_fifo_full;
    logic              tx_fifo_rd;
    logic              rx_fifo_wr;

    modport master (
        output cs, sck, mosi, dout, tx_fifo_rd, rx_fifo_wr,
        input  miso, din, freq, tx_fifo_empty, rx_fifo_full
    );

    modport slave (
        input  cs, sck, mosi, dout, tx_fifo_rd, rx_fifo_wr,
        output miso, din, freq, tx_fifo_empty, rx_fifo_full
    );
endinterface

// File: rtl/spi_v2_clkgen.sv
// Half-period tick generator for the SPI clock, driven by the latched freq.
module spi_v2_clkgen
    import spi_v2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_freq,
    output logic       o_tick_c
);

    logic [HP_W-1:0] r_cnt;
    logic [HP_W-1:0] w_half;

    assign w_half   = half_period(i_freq);
    assign o_tick_c = i_en && (r_cnt == (w_half - HP_W'(1)));

    // counter restarts whenever shifting stops so each byte begins with a full half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/spi_v2.sv
// Byte-oriented SPI master (mode 0, MSB first) between a TX FIFO and an RX FIFO.
// Define SPI_V2_LOOPBACK_EN to sample the rx path from mosi instead of miso.
module spi_v2
    import spi_v2_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CS_GAP = CS_GAP_DEF
) (
    input  logic     clk,
    input  logic     rst,
    spi_v2_if.master bus
);

    localparam int unsigned TICK_W = $clog2(2 * DATA_W);
    localparam int unsigned GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t             r_state;
    logic [DATA_W-1:0]  r_tx_sh;
    logic [DATA_W-1:0]  r_rx_sh;
    logic               r_last;
    logic [1:0]         r_freq;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_cs;
    logic               r_sck;
    logic               r_mosi;
    logic               r_rd;
    logic               r_wr;
    logic [DATA_W-1:0]  r_dout;

    logic w_tick;
    logic w_load;
    logic w_sample;
    logic w_shift_en;

    assign w_load     = ((r_state == IDLE) || (r_state == HOLD)) && !bus.tx_fifo_empty;
    assign w_shift_en = (r_state == SHIFT);

`ifdef SPI_V2_LOOPBACK_EN
    logic w_unused_miso;
    assign w_unused_miso = bus.miso;
    assign w_sample      = r_mosi;
`else
    assign w_sample      = bus.miso;
`endif

    spi_v2_clkgen u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_shift_en),
        .i_freq   (r_freq),
        .o_tick_c (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_last     <= 1'b0;
            r_freq     <= '0;
            r_tick_cnt <= '0;
            r_gap_cnt  <= '0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            case (r_state)
                IDLE, HOLD: begin
                    if (w_load) begin
                        r_tx_sh    <= bus.din[DATA_W-1:0];
                        r_last     <= bus.din[DATA_W];
                        r_freq     <= bus.freq;
                        r_mosi     <= bus.din[DATA_W-1];
                        r_cs       <= 1'b0;
                        r_rd       <= 1'b1;
                        r_tick_cnt <= '0;
                        r_state    <= SHIFT;
                    end
                end
                // even tick count = rising edge (sample), odd = falling edge (next bit out)
                SHIFT: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        if (!r_tick_cnt[0]) begin
                            r_sck   <= 1'b1;
                            r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_sample};
                        end else begin
                            r_sck <= 1'b0;
                            if (r_tick_cnt == TICK_W'(2 * DATA_W - 1)) begin
                                r_state <= STORE;
                            end else begin
                                r_tx_sh <= r_tx_sh << 1;
                                r_mosi  <= r_tx_sh[DATA_W-2];
                            end
                        end
                    end
                end
                STORE: begin
                    if (!bus.rx_fifo_full) begin
                        r_dout <= r_rx_sh;
                        r_wr   <= 1'b1;
                        if (r_last) begin
                            r_cs      <= 1'b1;
                            r_gap_cnt <= '0;
                            r_state   <= GAP;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cs         = r_cs;
    assign bus.sck        = r_sck;
    assign bus.mosi       = r_mosi;
    assign bus.dout       = r_dout;
    assign bus.tx_fifo_rd = r_rd;
    assign bus.rx_fifo_wr = r_wr;

endmodule

// File: tb/tb_spi_v2.sv
// Directed self-checking bench for spi_v2 with a mode-0 slave model on miso.
module tb_spi_v2;

`ifdef SPI_V2_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_v2_if #(.DATA_W(8)) bus ();

    spi_v2 #(.DATA_W(8), .CS_GAP(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // monitor state
    int         cyc, rd_cnt, wr_cnt, rise_cnt, fall_cnt, sck_hi, cs_rise, cs_fall;
    int         cs_fall_cyc, last_fall_cyc, mbit, mcnt;
    logic [7:0] mosi_sh, slave_sh, slave_byte;
    logic [7:0] tx_log [4];
    logic [7:0] rx_log [4];
    logic       prev_cs  = 1'b1;
    logic       prev_sck = 1'b0;
    logic       mon_clr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sl);
        return LB ? tx : sl;
    endfunction

    // bus monitor and slave model: slave shifts miso MSB first, updating after each sck fall
    initial begin
        bus.miso = 1'b0;
        slave_sh = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_clr) begin
                rd_cnt = 0; wr_cnt = 0; rise_cnt = 0; fall_cnt = 0; sck_hi = 0;
                cs_rise = 0; cs_fall = 0; cs_fall_cyc = 0; last_fall_cyc = 0;
                mbit = 0; mcnt = 0; mosi_sh = 8'h00;
            end else begin
                if (bus.tx_fifo_rd) rd_cnt++;
                if (bus.rx_fifo_wr) begin
                    if (wr_cnt < 4) rx_log[wr_cnt] = bus.dout;
                    wr_cnt++;
                end
                if (bus.sck) sck_hi++;
                if (!bus.cs && prev_cs) begin
                    cs_fall++;
                    cs_fall_cyc = cyc;
                    slave_sh    = slave_byte;
                    bus.miso    = slave_sh[7];
                end
                if (bus.cs && !prev_cs) cs_rise++;
                if (bus.sck && !prev_sck) begin
                    rise_cnt++;
                    mosi_sh = {mosi_sh[6:0], bus.mosi};
                    mbit++;
                    if (mbit == 8) begin
                        if (mcnt < 4) tx_log[mcnt] = mosi_sh;
                        mcnt++;
                        mbit = 0;
                    end
                end
                if (!bus.sck && prev_sck) begin
                    fall_cnt++;
                    last_fall_cyc = cyc;
                    slave_sh      = {slave_sh[6:0], slave_sh[7]};
                    bus.miso      = slave_sh[7];
                end
            end
            prev_cs  = bus.cs;
            prev_sck = bus.sck;
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        #1 mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // present one word at the FIFO head and retire it once the pop strobe is seen
    task automatic send(input logic [8:0] w);
        int  start;
        bit  got;
        start = rd_cnt;
        got   = 1'b0;
        bus.din           = w;
        bus.tx_fifo_empty = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            #1;
            got = (rd_cnt > start);
        end
        bus.tx_fifo_empty = 1'b1;
    endtask

    task automatic wait_cs_rise(input string tag, input int n);
        for (int i = 0; i < 2000 && cs_rise < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, cs_rise, n);
    endtask

    initial begin
        bus.din           = 9'h000;
        bus.tx_fifo_empty = 1'b1;
        bus.rx_fifo_full  = 1'b0;
        bus.freq          = 2'b00;
        slave_byte        = 8'h00;
        rst               = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs",   bus.cs,         1);
        chk("rst_sck",  bus.sck,        0);
        chk("rst_mosi", bus.mosi,       0);
        chk("rst_dout", bus.dout,       0);
        chk("rst_rd",   bus.tx_fifo_rd, 0);
        chk("rst_wr",   bus.rx_fifo_wr, 0);
        @(negedge clk);
        rst = 1'b0;

        // single-byte frame at full speed
        bus.freq = 2'b00; slave_byte = 8'hFF;
        clear_mon();
        send(9'h1FF);
        wait_cs_rise("t1_end", 1);
        chk("t1_rd",    rd_cnt, 1);
        chk("t1_rises", rise_cnt, 8);
        chk("t1_sckhi", sck_hi, 8);
        chk("t1_len",   last_fall_cyc - cs_fall_cyc, 16);
        chk("t1_mosi",  tx_log[0], 8'hFF);
        chk("t1_wr",    wr_cnt, 1);
        chk("t1_rx",    rx_log[0], 8'hFF);
        chk("t1_dout",  bus.dout, 8'hFF);
        chk("t1_cs",    bus.cs, 1);

        // two-byte frame, cs held low across both
        slave_byte = 8'h00;
        clear_mon();
        send(9'h0EF);
        send(9'h101);
        wait_cs_rise("t2_end", 1);
        chk("t2_csfall", cs_fall, 1);
        chk("t2_rd",     rd_cnt, 2);
        chk("t2_nbytes", mcnt, 2);
        chk("t2_mosi0",  tx_log[0], 8'hEF);
        chk("t2_mosi1",  tx_log[1], 8'h01);
        chk("t2_wr",     wr_cnt, 2);
        chk("t2_rx0",    rx_log[0], exp_rx(8'hEF, 8'h00));
        chk("t2_rx1",    rx_log[1], exp_rx(8'h01, 8'h00));

        // slowest divider
        bus.freq = 2'b11; slave_byte = 8'h5A;
        clear_mon();
        send(9'h1A5);
        bus.freq = 2'b00;
        wait_cs_rise("t3_end", 1);
        chk("t3_rises", rise_cnt, 8);
        chk("t3_sckhi", sck_hi, 64);
        chk("t3_len",   last_fall_cyc - cs_fall_cyc, 128);
        chk("t3_mosi",  tx_log[0], 8'hA5);
        chk("t3_rx",    rx_log[0], exp_rx(8'hA5, 8'h5A));

        // RX FIFO full at byte end
        bus.rx_fifo_full = 1'b1; slave_byte = 8'h3C;
        clear_mon();
        send(9'h1C3);
        for (int i = 0; i < 400 && fall_cnt < 8; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (10) @(negedge clk);
        #1;
        chk("t4_falls",   fall_cnt, 8);
        chk("t4_nowr",    wr_cnt, 0);
        chk("t4_cs_low",  bus.cs, 0);
        chk("t4_sck_low", bus.sck, 0);
        bus.rx_fifo_full = 1'b0;
        wait_cs_rise("t4_end", 1);
        chk("t4_wr",   wr_cnt, 1);
        chk("t4_rx",   rx_log[0], exp_rx(8'hC3, 8'h3C));
        chk("t4_mosi", tx_log[0], 8'hC3);

        // asynchronous reset mid-byte
        bus.freq = 2'b01; slave_byte = 8'hFF;
        clear_mon();
        send(9'h1FF);
        for (int i = 0; i < 400 && rise_cnt < 3; i++) begin
            @(negedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("t5_cs",   bus.cs,         1);
        chk("t5_sck",  bus.sck,        0);
        chk("t5_mosi", bus.mosi,       0);
        chk("t5_dout", bus.dout,       0);
        chk("t5_rd",   bus.tx_fifo_rd, 0);
        chk("t5_wr",   bus.rx_fifo_wr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (40) @(negedge clk);
        #1;
        chk("t5_idle_rd",    rd_cnt, 0);
        chk("t5_idle_wr",    wr_cnt, 0);
        chk("t5_idle_rises", rise_cnt, 0);
        chk("t5_idle_cs",    bus.cs, 1);
        slave_byte = 8'h96;
        send(9'h181);
        wait_cs_rise("t5_end", 1);
        chk("t5_post_rd", rd_cnt, 1);
        chk("t5_post_wr", wr_cnt, 1);
        chk("t5_post_rx", rx_log[0], exp_rx(8'h81, 8'h96));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
